// File: rtl/calendar_pkg.sv
// Shared encodings and field limits for the calendar counter chain.
package calendar_pkg;

    typedef enum logic [2:0] {
        MODE_RUN      = 3'd0,
        MODE_SET_SEC  = 3'd1,
        MODE_SET_MIN  = 3'd2,
        MODE_SET_HOUR = 3'd3,
        MODE_SET_DAY  = 3'd4,
        MODE_SET_MON  = 3'd5,
        MODE_SET_YEAR = 3'd6
    } mode_e;

    localparam int SEC        = 0;
    localparam int MIN        = 1;
    localparam int HOUR       = 2;
    localparam int DAY        = 3;
    localparam int MON        = 4;
    localparam int YEAR       = 5;
    localparam int NUM_FIELDS = 6;

    localparam logic [15:0] SEC_MAX  = 16'd59;
    localparam logic [15:0] MIN_MAX  = 16'd59;
    localparam logic [15:0] HOUR_MAX = 16'd23;
    localparam logic [15:0] MON_MAX  = 16'd12;

endpackage

// File: rtl/calendar_day_limit.sv
// Combinational days-in-month lookup with Gregorian leap-year rule.
module calendar_day_limit (
    input  logic [15:0] mon_i,
    input  logic [15:0] year_i,
    output logic [15:0] day_lim_o
);

    logic leap;

    assign leap = ((year_i % 16'd4) == 16'd0) &&
                  (((year_i % 16'd100) != 16'd0) || ((year_i % 16'd400) == 16'd0));

    // Out-of-range months fall through to 31.
    always_comb begin
        day_lim_o = 16'd31;
        case (mon_i)
            16'd2:                      day_lim_o = leap ? 16'd29 : 16'd28;
            16'd4, 16'd6, 16'd9, 16'd11: day_lim_o = 16'd30;
            default:                    day_lim_o = 16'd31;
        endcase
    end

endmodule

// File: rtl/calendar_chain_ctrl.sv
// Carry-chain enable generator, day-limit register and key-driven time-set FSM
// for the calendar's cascade of modulo counters.
module calendar_chain_ctrl
    import calendar_pkg::*;
#(
    parameter int YEAR_MAX  = 9999,
    parameter int TIMEOUT_S = 30
) (
    input  logic        CP,
    input  logic        nCR,
    input  logic        tick,
    input  logic        key_mode,
    input  logic        key_inc,
    input  logic [15:0] sec_q,
    input  logic [15:0] min_q,
    input  logic [15:0] hour_q,
    input  logic [15:0] day_q,
    input  logic [15:0] mon_q,
    input  logic [15:0] year_q,
    output logic [5:0]  en,
    output logic [15:0] day_max,
    output logic [2:0]  mode,
    output logic        set_active
);

    localparam int IDLE_W = $clog2(TIMEOUT_S + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S - 1);

    mode_e                 state_q, state_d;
    logic                  mode_dly_q, inc_dly_q;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic [NUM_FIELDS-1:0] en_q, en_d;
    logic [15:0]           day_max_q, day_lim;
    logic                  mode_edge, inc_edge;
    logic [NUM_FIELDS-1:0] carry;

    calendar_day_limit u_day_limit (
        .mon_i     (mon_q),
        .year_i    (year_q),
        .day_lim_o (day_lim)
    );

    assign mode_edge = key_mode & ~mode_dly_q;
    assign inc_edge  = key_inc  & ~inc_dly_q;

    // Day carry compares against the registered limit; fields are stable between enables.
    assign carry[SEC]  = tick;
    assign carry[MIN]  = carry[SEC]  & (sec_q  >= SEC_MAX);
    assign carry[HOUR] = carry[MIN]  & (min_q  >= MIN_MAX);
    assign carry[DAY]  = carry[HOUR] & (hour_q >= HOUR_MAX);
    assign carry[MON]  = carry[DAY]  & (day_q  >= day_max_q);
    assign carry[YEAR] = carry[MON]  & (mon_q  >= MON_MAX);

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        en_d    = '0;
        case (state_q)
            MODE_RUN: begin
                idle_d = '0;
                en_d   = carry;
                if (mode_edge) state_d = MODE_SET_SEC;
            end
            MODE_SET_SEC, MODE_SET_MIN, MODE_SET_HOUR,
            MODE_SET_DAY, MODE_SET_MON, MODE_SET_YEAR: begin
                if (mode_edge) begin
                    state_d = (state_q == MODE_SET_YEAR) ? MODE_RUN : mode_e'(state_q + 3'd1);
                    idle_d  = '0;
                end else if (inc_edge) begin
                    // Set states are ordered like the field indices, offset by one.
                    en_d   = NUM_FIELDS'(1) << (state_q - 3'd1);
                    idle_d = '0;
                end else if (tick) begin
                    if (idle_q == IDLE_LAST) begin
                        state_d = MODE_RUN;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = MODE_RUN;
                idle_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state_q    <= MODE_RUN;
            mode_dly_q <= 1'b0;
            inc_dly_q  <= 1'b0;
            idle_q     <= '0;
            en_q       <= '0;
            day_max_q  <= 16'd31;
        end else begin
            state_q    <= state_d;
            mode_dly_q <= key_mode;
            inc_dly_q  <= key_inc;
            idle_q     <= idle_d;
            en_q       <= en_d;
            day_max_q  <= day_lim;
        end
    end

    assign en         = en_q;
    assign day_max    = day_max_q;
    assign mode       = state_q;
    assign set_active = state_q inside {MODE_SET_SEC, MODE_SET_MIN, MODE_SET_HOUR,
                                        MODE_SET_DAY, MODE_SET_MON, MODE_SET_YEAR};

endmodule

// File: tb/tb_calendar_chain_ctrl.sv
// Directed bench for calendar_chain_ctrl: en pulses checked through a scoreboard queue.
module tb_calendar_chain_ctrl;

    logic        CP = 1'b0;
    logic        nCR = 1'b1;
    logic        tick = 1'b0;
    logic        key_mode = 1'b0;
    logic        key_inc = 1'b0;
    logic [15:0] sec_q = 16'd0, min_q = 16'd0, hour_q = 16'd0;
    logic [15:0] day_q = 16'd1, mon_q = 16'd1, year_q = 16'd2023;
    logic [5:0]  en;
    logic [15:0] day_max;
    logic [2:0]  mode;
    logic        set_active;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] en;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    calendar_chain_ctrl #(.YEAR_MAX(9999), .TIMEOUT_S(30)) dut (
        .CP         (CP),
        .nCR        (nCR),
        .tick       (tick),
        .key_mode   (key_mode),
        .key_inc    (key_inc),
        .sec_q      (sec_q),
        .min_q      (min_q),
        .hour_q     (hour_q),
        .day_q      (day_q),
        .mon_q      (mon_q),
        .year_q     (year_q),
        .en         (en),
        .day_max    (day_max),
        .mode       (mode),
        .set_active (set_active)
    );

    always #5 CP = ~CP;

    // Monitor: every nonzero en must match the oldest expected pulse.
    always @(negedge CP) begin
        if (nCR && en != 6'd0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_en got %b expected no pulse", en);
            end else begin
                mon_e = sb.pop_front();
                if (en !== mon_e.en) begin
                    errors++;
                    $display("FAIL %s got en=%b expected en=%b", mon_e.name, en, mon_e.en);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CP);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic drained(input string nm);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s got %0d pending pulses expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_tick(input logic [5:0] exp_en, input string nm);
        if (exp_en != 6'd0) sb.push_back('{exp_en, nm});
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(2);
    endtask

    task automatic press_mode(input int n);
        repeat (n) begin
            key_mode = 1'b1;
            cyc(1);
            key_mode = 1'b0;
            cyc(1);
        end
    endtask

    task automatic fields(input logic [15:0] s, m, h, d, mo, y);
        sec_q = s; min_q = m; hour_q = h; day_q = d; mon_q = mo; year_q = y;
    endtask

    initial begin
        #2 nCR = 1'b0;
        #1;
        chk("rst_mode", 16'(mode), 16'd0);
        chk("rst_en", 16'(en), 16'd0);
        chk("rst_day_max", day_max, 16'd31);
        chk("rst_set_active", 16'(set_active), 16'd0);
        cyc(2);
        nCR = 1'b1;

        // Full carry chain and partial carries
        fields(59, 59, 23, 31, 12, 2023);
        cyc(2);
        do_tick(6'b111111, "full_carry");
        chk("run_mode", 16'(mode), 16'd0);
        chk("run_day_max", day_max, 16'd31);
        fields(10, 59, 23, 31, 12, 2023);
        do_tick(6'b000001, "sec_only");
        fields(59, 10, 23, 31, 12, 2023);
        do_tick(6'b000011, "sec_min");
        fields(59, 59, 5, 31, 12, 2023);
        do_tick(6'b000111, "to_hour");
        fields(59, 59, 23, 15, 12, 2023);
        do_tick(6'b001111, "to_day");
        drained("run_drain");

        // Day limit table
        fields(0, 0, 0, 1, 2, 2024); cyc(2); chk("feb_2024", day_max, 16'd29);
        year_q = 16'd1900;           cyc(2); chk("feb_1900", day_max, 16'd28);
        year_q = 16'd2000;           cyc(2); chk("feb_2000", day_max, 16'd29);
        mon_q = 16'd4;               cyc(2); chk("apr", day_max, 16'd30);
        mon_q = 16'd0;               cyc(2); chk("mon0", day_max, 16'd31);
        mon_q = 16'd13;              cyc(2); chk("mon13", day_max, 16'd31);
        fields(59, 59, 23, 28, 2, 2023); cyc(2);
        do_tick(6'b011111, "feb28_carry");
        drained("limit_drain");

        // Set mode stepping and increment pulses
        press_mode(3);
        chk("set_hour_mode", 16'(mode), 16'd3);
        chk("set_hour_active", 16'(set_active), 16'd1);
        sb.push_back('{6'b000100, "inc_hour"});
        key_inc = 1'b1;
        cyc(4);
        key_inc = 1'b0;
        cyc(1);
        drained("inc_hour_drain");
        do_tick(6'b000000, "tick_in_set");
        drained("set_tick_drain");

        // Simultaneous mode and inc edges in SET_MIN
        press_mode(6);
        chk("set_min_mode", 16'(mode), 16'd2);
        key_mode = 1'b1;
        key_inc = 1'b1;
        cyc(1);
        key_mode = 1'b0;
        key_inc = 1'b0;
        cyc(2);
        chk("simul_mode", 16'(mode), 16'd3);
        drained("simul_drain");

        // Timeout from SET_SEC
        press_mode(4);
        chk("back_to_run", 16'(mode), 16'd0);
        fields(0, 0, 0, 1, 1, 2023);
        press_mode(1);
        chk("set_sec_mode", 16'(mode), 16'd1);
        repeat (29) do_tick(6'b000000, "idle_tick");
        chk("pre_timeout_mode", 16'(mode), 16'd1);
        do_tick(6'b000000, "tick30");
        chk("timeout_mode", 16'(mode), 16'd0);
        chk("timeout_active", 16'(set_active), 16'd0);
        do_tick(6'b000001, "tick31");
        drained("timeout_drain");

        // Reset mid-press in SET_YEAR
        fields(0, 0, 0, 1, 2, 2023);
        cyc(2);
        chk("pre_rst_day_max", day_max, 16'd28);
        press_mode(6);
        chk("set_year_mode", 16'(mode), 16'd6);
        sb.push_back('{6'b100000, "inc_year"});
        key_inc = 1'b1;
        cyc(3);
        nCR = 1'b0;
        #1;
        chk("midrst_mode", 16'(mode), 16'd0);
        chk("midrst_en", 16'(en), 16'd0);
        chk("midrst_day_max", day_max, 16'd31);
        chk("midrst_active", 16'(set_active), 16'd0);
        cyc(2);
        nCR = 1'b1;
        cyc(4);
        key_inc = 1'b0;
        cyc(2);
        key_inc = 1'b1;
        cyc(2);
        key_inc = 1'b0;
        cyc(2);
        drained("post_rst_drain");
        chk("post_rst_mode", 16'(mode), 16'd0);
        chk("post_rst_day_max", day_max, 16'd28);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
